// File: rtl/layer5_pkg.sv
// Shared constants, FSM state encodings and the score conversion helper for the layer-5
// result collector.
package layer5_pkg;

  localparam int ACC_W     = 24;
  localparam int SCORE_W   = 16;
  localparam int NUM_CLASS = 10;
  localparam int IDX_W     = 4;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] ARGMAX  = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  // Clamp a signed accumulator word into the signed score range.
  function automatic logic [SCORE_W-1:0] sat_score(input logic [ACC_W-1:0] acc);
    logic [ACC_W-SCORE_W:0] upper;
    upper = acc[ACC_W-1:SCORE_W-1];
    if ((&upper) || !(|upper)) begin
      return acc[SCORE_W-1:0];
    end else if (acc[ACC_W-1]) begin
      return {1'b1, {(SCORE_W-1){1'b0}}};
    end else begin
      return {1'b0, {(SCORE_W-1){1'b1}}};
    end
  endfunction

endpackage

// File: rtl/layer5_score_rf.sv
// Class-score register file: one synchronous write port, one asynchronous read port, no reset.
module layer5_score_rf #(
  parameter int DEPTH = 10,
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/layer5_result_collector.sv
// Collects NUM_CLASS accumulator words, runs a sequential argmax and offers the winner on a
// valid/ready port. Define LAYER5_SCORE_SAT_EN to saturate instead of truncate incoming words.
module layer5_result_collector #(
  parameter int ACC_W     = layer5_pkg::ACC_W,
  parameter int SCORE_W   = layer5_pkg::SCORE_W,
  parameter int NUM_CLASS = layer5_pkg::NUM_CLASS,
  parameter int IDX_W     = layer5_pkg::IDX_W
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               start_i,
  input  logic               temp_wr_i,
  input  logic [ACC_W-1:0]   acc_i,
  output logic [IDX_W-1:0]   class_o,
  output logic [SCORE_W-1:0] score_o,
  output logic               class_valid_o,
  input  logic               class_ready_i,
  output logic               busy_o,
  output logic               overflow_o
);

  import layer5_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASS - 1);

  logic [1:0]         state;
  logic [IDX_W-1:0]   wr_ptr;
  logic [IDX_W-1:0]   rd_ptr;
  logic [SCORE_W-1:0] best_score;
  logic [IDX_W-1:0]   best_idx;
  logic [SCORE_W-1:0] conv_score;
  logic [SCORE_W-1:0] rd_score;
  logic               rf_we;
  logic               take;
  logic [SCORE_W-1:0] nxt_score;
  logic [IDX_W-1:0]   nxt_idx;

`ifdef LAYER5_SCORE_SAT_EN
  assign conv_score = sat_score(acc_i);
`else
  logic unused_acc;
  assign unused_acc = ^acc_i[ACC_W-1:SCORE_W];
  assign conv_score = acc_i[SCORE_W-1:0];
`endif

  assign rf_we = (state == COLLECT) && temp_wr_i;

  layer5_score_rf #(
    .DEPTH (NUM_CLASS),
    .WIDTH (SCORE_W),
    .AW    (IDX_W)
  ) u_score_rf (
    .clk   (clk_i),
    .we    (rf_we),
    .waddr (wr_ptr),
    .wdata (conv_score),
    .raddr (rd_ptr),
    .rdata (rd_score)
  );

  // Strictly-greater replacement keeps the lowest index on ties.
  always_comb begin
    take      = (rd_ptr == '0) || ($signed(rd_score) > $signed(best_score));
    nxt_score = take ? rd_score : best_score;
    nxt_idx   = take ? rd_ptr : best_idx;
  end

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      best_score    <= '0;
      best_idx      <= '0;
      class_o       <= '0;
      score_o       <= '0;
      class_valid_o <= 1'b0;
      overflow_o    <= 1'b0;
    end else begin
      if (temp_wr_i && (state != COLLECT)) begin
        overflow_o <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start_i) begin
            state         <= COLLECT;
            wr_ptr        <= '0;
            overflow_o    <= 1'b0;
            class_valid_o <= 1'b0;
          end
        end
        COLLECT: begin
          if (temp_wr_i) begin
            if (wr_ptr == LAST_IDX) begin
              state  <= ARGMAX;
              rd_ptr <= '0;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        ARGMAX: begin
          best_score <= nxt_score;
          best_idx   <= nxt_idx;
          rd_ptr     <= rd_ptr + 1'b1;
          if (rd_ptr == LAST_IDX) begin
            class_o       <= nxt_idx;
            score_o       <= nxt_score;
            class_valid_o <= 1'b1;
            state         <= HOLD;
          end
        end
        HOLD: begin
          if (class_valid_o && class_ready_i) begin
            class_valid_o <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/layer5_result_collector.md
# layer5_result_collector

Receiving end of the layer-5 accumulator write strobe. Captures one accumulator word per `temp_wr_i` pulse into a class-score buffer. Once all class scores are in, it runs a sequential argmax and presents the winning class index and its score to the top-level result port with a valid/ready handshake. It sits between the layer-5 MAC/accumulator and the classification output of the MNIST streamline datapath.

## Interface
Parameters:
- `ACC_W`, 24, width of the incoming signed accumulator word.
- `SCORE_W`, 16, width of a stored signed score.
- `NUM_CLASS`, 10, number of scores per image.
- `IDX_W`, 4, class index width; must satisfy 2^IDX_W ≥ NUM_CLASS.

Ports:
- `clk_i`  in  1  single clock; all logic on the rising edge.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  arms collection for a new image; honoured only in IDLE.
- `temp_wr_i`  in  1  one-cycle strobe; `acc_i` is valid in the same cycle.
- `acc_i`  in  ACC_W  signed accumulator result.
- `class_o`  out  IDX_W  winning class index.
- `score_o`  out  SCORE_W  winning score.
- `class_valid_o`  out  1  result valid.
- `class_ready_i`  in  1  downstream accepts the result.
- `busy_o`  out  1  high in COLLECT, ARGMAX and HOLD.
- `overflow_o`  out  1  sticky error flag: a strobe arrived outside COLLECT.

## Operation
- State machine: IDLE → COLLECT → ARGMAX → HOLD → IDLE.
- IDLE:
  - `start_i` → COLLECT.
  - On that edge: `wr_ptr`=0, `overflow_o` cleared, `class_valid_o`=0.
- COLLECT:
  - Each `temp_wr_i`: `buf[wr_ptr]` ← conv(`acc_i`), then `wr_ptr`++.
  - A write with `wr_ptr`=NUM_CLASS-1 → ARGMAX, with `rd_ptr`=0.
- ARGMAX (one entry per cycle, `rd_ptr` 0..NUM_CLASS-1):
  - Entry 0 loads `best_score`/`best_idx` unconditionally.
  - Later entries replace the best only if strictly greater (signed compare), so ties keep the lowest index.
  - After entry NUM_CLASS-1: `class_o`/`score_o` ← best, `class_valid_o`=1, → HOLD.
- HOLD:
  - `class_o`, `score_o` and `class_valid_o` stay stable until `class_valid_o && class_ready_i`.
  - On that handshake edge: `class_valid_o`=0, → IDLE.
  - `class_o` and `score_o` keep their last values in IDLE.
- `temp_wr_i` in IDLE, ARGMAX or HOLD: data discarded, no state change, `overflow_o` ← 1.
- `overflow_o` holds until the next accepted `start_i` or reset.
- `start_i` outside IDLE: ignored.
- `busy_o` is a decode of the state (not IDLE).
- conv(): see Configuration. Arithmetic is signed throughout.
- Reset (async, any state):
  - Outputs: `class_o`=0, `score_o`=0, `class_valid_o`=0, `busy_o`=0, `overflow_o`=0.
  - Internal: state=IDLE, `wr_ptr`=0, `rd_ptr`=0.
  - The score buffer is not reset. Reset mid-collection abandons the image.

## Timing
- Let edge k sample the final `temp_wr_i`.
- ARGMAX occupies edges k+1 .. k+NUM_CLASS.
- `class_valid_o` rises after edge k+NUM_CLASS (10 cycles after k for the default).
- Earliest re-arm: `start_i` is accepted on the edge after the handshake edge.
- Back-to-back strobes in COLLECT (every cycle) are supported with zero bubbles.
- `class_ready_i` may be held high continuously; the result is then valid for exactly one cycle.

## Configuration
- Macro: `LAYER5_SCORE_SAT_EN`.
- Defined: conv() saturates `acc_i` to the signed SCORE_W range.
  - Values above 2^(SCORE_W-1)-1 clamp to the maximum; values below -2^(SCORE_W-1) clamp to the minimum.
- Undefined: conv() takes `acc_i[SCORE_W-1:0]` (wrap-around truncation).

## Structure
- Package `layer5_pkg` holds:
  - `NUM_CLASS`, `SCORE_W` and `IDX_W` constants;
  - the state enum (IDLE, COLLECT, ARGMAX, HOLD);
  - the saturating-convert function.
- Sub-module `layer5_score_rf`: NUM_CLASS×SCORE_W register file, one write port and one asynchronous read port, no reset.
- The FSM, pointers, comparator and output registers live in the top module.

## Test plan
- Reset, `start_i`, then 10 strobes with scores 5,-3,9,9,0,1,2,3,4,-8 → `class_o`=2, `score_o`=9. Valid rises 10 cycles after the last strobe.
- Result held with `class_ready_i`=0 for 20 cycles → `class_o`/`score_o` stable, `class_valid_o` stays 1. Asserting ready → valid drops the next cycle and the block returns to IDLE.
- With `LAYER5_SCORE_SAT_EN`: `acc_i`=0x010000 as class 7, others 0 → `score_o`=0x7FFF, `class_o`=7. Without the macro, the same stimulus → class 7 stored as 0 and `class_o`=0 (tie keeps the lowest index).
- Strobe while in IDLE, then in HOLD → `overflow_o`=1, result unchanged. Next `start_i` clears the flag.
- Deassert `rstn_i` after 5 of 10 strobes → all outputs 0 immediately. A fresh `start_i` plus 10 strobes yields the correct argmax.
- All 10 scores = -32768 → `class_o`=0, `score_o`=0x8000.
